// File: rtl/pixie_pkg.sv
// Shared definitions for the Pixie video DMA fetch engine: FSM encoding,
// default display-window geometry and the windowed address helper.
package pixie_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitDma,
    StXfer,
    StLineEnd
  } pixie_state_e;

  localparam logic [15:0] DefStartAddr    = 16'h0900;
  localparam int unsigned DefBytesPerRow  = 8;
  localparam int unsigned DefLinesPerRow  = 4;
  localparam int unsigned DefRowsPerFrame = 32;

  // CDP1802 state code for a DMA cycle
  localparam logic [1:0] ScDma = 2'b10;

  // Address inside the 256-byte display window; offsets wrap mod 256.
  function automatic logic [15:0] window_addr(input logic [15:0] base, input logic [7:0] off);
    return base + {8'h00, off};
  endfunction

endpackage

// File: rtl/pixie_dma_fetch.sv
// Pixie video DMA fetch: walks the display window one scan line at a time,
// repeating each memory row LINES_PER_ROW times, and streams the fetched bytes
// into a line buffer.
module pixie_dma_fetch
  import pixie_pkg::*;
#(
  parameter logic [15:0] START_ADDR     = DefStartAddr,
  parameter int unsigned BYTES_PER_ROW  = DefBytesPerRow,
  parameter int unsigned LINES_PER_ROW  = DefLinesPerRow,
  parameter int unsigned ROWS_PER_FRAME = DefRowsPerFrame
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [1:0]  SC,
  input  logic        DMAO,
  input  logic        frame_start,
  input  logic [7:0]  data_in,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        wr_en,
  output logic [2:0]  wr_idx,
  output logic [7:0]  wr_data,
  output logic        line_done,
  output logic        frame_done
);

  localparam logic [2:0] LastByte = 3'(BYTES_PER_ROW - 1);
  localparam logic [7:0] LastRep  = 8'(LINES_PER_ROW - 1);
  localparam logic [7:0] LastRow  = 8'(ROWS_PER_FRAME - 1);
  localparam logic [7:0] RowStep  = 8'(BYTES_PER_ROW);

  pixie_state_e state;
  logic [7:0]   addr_off;  // fetch offset within the window
  logic [7:0]   row_off;   // offset of the current memory row
  logic [2:0]   byte_idx;
  logic [7:0]   line_rep;
  logic [7:0]   row;
  logic         dma_go;

  // A byte is fetched on a DMA bus cycle; the first byte of a line also needs
  // DMAO, later bytes ignore it so a mid-line deassertion just pauses.
  always_comb begin
    dma_go = 1'b0;
    if (clk_enable && (SC == ScDma)) begin
      dma_go = (state == StXfer) || ((state == StWaitDma) && !DMAO);
    end
  end

  assign mem_addr = window_addr(START_ADDR, addr_off);
  assign mem_rd   = dma_go && !reset;

  // Fetch FSM, counters and registered line-buffer / pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      addr_off   <= 8'h00;
      row_off    <= 8'h00;
      byte_idx   <= 3'd0;
      line_rep   <= 8'h00;
      row        <= 8'h00;
      wr_en      <= 1'b0;
      wr_idx     <= 3'd0;
      wr_data    <= 8'h00;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      // frame_start is a single-clk pulse, so it is taken regardless of
      // clk_enable to avoid losing it; it overrides any transition.
      if (frame_start) begin
        state    <= StWaitDma;
        addr_off <= 8'h00;
        row_off  <= 8'h00;
        byte_idx <= 3'd0;
        line_rep <= 8'h00;
        row      <= 8'h00;
      end else if (clk_enable) begin
        unique case (state)
          StIdle: ;
          StWaitDma, StXfer: begin
            if (dma_go) begin
              wr_en    <= 1'b1;
              wr_idx   <= byte_idx;
              wr_data  <= data_in;
              addr_off <= addr_off + 8'd1;
              if (byte_idx == LastByte) begin
                byte_idx <= 3'd0;
                state    <= StLineEnd;
              end else begin
                byte_idx <= byte_idx + 3'd1;
                state    <= StXfer;
              end
            end
          end
          StLineEnd: begin
            line_done <= 1'b1;
            state     <= StWaitDma;
            if (line_rep != LastRep) begin
              addr_off <= row_off;
              line_rep <= line_rep + 8'd1;
            end else begin
              row_off  <= row_off + RowStep;
              addr_off <= row_off + RowStep;
              line_rep <= 8'h00;
              if (row == LastRow) begin
                frame_done <= 1'b1;
                row        <= 8'h00;
                state      <= StIdle;
              end else begin
                row <= row + 8'd1;
              end
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixie_dma_fetch.sv
// Self-checking bench for pixie_dma_fetch: fixed vector table, hand-written
// corner sequences and a randomized full frame against a protocol-level model.
module tb_pixie_dma_fetch;

  localparam int unsigned BPR   = 8;
  localparam int unsigned LPR   = 4;
  localparam int unsigned RPF   = 32;
  localparam logic [15:0] START = 16'h0900;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic [1:0]  SC;
  logic        DMAO;
  logic        frame_start;
  logic [7:0]  data_in;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [7:0]  wr_data;
  logic        line_done;
  logic        frame_done;

  pixie_dma_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .SC          (SC),
    .DMAO        (DMAO),
    .frame_start (frame_start),
    .data_in     (data_in),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .line_done   (line_done),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: bytes fetched this frame, pending line-end slot, frame active.
  int unsigned m_k      = 0;
  bit          m_gap    = 1'b0;
  bit          m_active = 1'b0;

  // Sampled DUT values from the last tick.
  logic        s_rd;
  logic [15:0] s_addr;
  logic        s_wr;
  logic [2:0]  s_idx;
  logic [7:0]  s_data;
  logic        s_ld;
  logic        s_fd;
  int          ld_cnt = 0;
  int          fd_cnt = 0;

  typedef struct {
    logic [1:0]  sc;
    bit          dmao;
    logic [7:0]  din;
    bit          rd;
    bit          chk_addr;
    logic [15:0] addr;
    bit          wr;
    logic [2:0]  idx;
    bit          ld;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check combinational fetch outputs before the edge
  // and registered outputs after it, advancing the reference model.
  task automatic tick(input bit ce, input logic [1:0] sc, input bit dmao, input bit fs,
                      input bit rst, input logic [7:0] din);
    bit          exp_rd;
    bit          exp_wr;
    bit          exp_ld;
    bit          exp_fd;
    int unsigned exp_idx;
    logic [15:0] exp_addr;
    clk_enable  = ce;
    SC          = sc;
    DMAO        = dmao;
    frame_start = fs;
    reset       = rst;
    data_in     = din;
    exp_rd = !rst && m_active && !m_gap && ce && (sc == 2'b10) && (((m_k % BPR) != 0) || !dmao);
    exp_addr = START + 16'((((m_k / BPR) / LPR) * BPR + (m_k % BPR)) % 256);
    @(negedge clk);
    s_rd   = mem_rd;
    s_addr = mem_addr;
    chk("mem_rd", 32'(s_rd), 32'(exp_rd));
    if (exp_rd) chk("mem_addr", 32'(s_addr), 32'(exp_addr));
    exp_wr  = 1'b0;
    exp_ld  = 1'b0;
    exp_fd  = 1'b0;
    exp_idx = 0;
    if (rst) begin
      m_active = 1'b0;
      m_k      = 0;
      m_gap    = 1'b0;
    end else if (fs) begin
      m_active = 1'b1;
      m_k      = 0;
      m_gap    = 1'b0;
    end else if (ce && m_gap) begin
      exp_ld = 1'b1;
      m_gap  = 1'b0;
      if (m_k == BPR * LPR * RPF) begin
        exp_fd   = 1'b1;
        m_active = 1'b0;
      end
    end else if (exp_rd) begin
      exp_wr  = 1'b1;
      exp_idx = m_k % BPR;
      m_k++;
      if ((m_k % BPR) == 0) m_gap = 1'b1;
    end
    @(posedge clk);
    #1;
    s_wr   = wr_en;
    s_idx  = wr_idx;
    s_data = wr_data;
    s_ld   = line_done;
    s_fd   = frame_done;
    if (s_ld) ld_cnt++;
    if (s_fd) fd_cnt++;
    chk("wr_en", 32'(s_wr), 32'(exp_wr));
    if (exp_wr) begin
      chk("wr_idx", 32'(s_idx), exp_idx);
      chk("wr_data", 32'(s_data), 32'(din));
    end
    chk("line_done", 32'(s_ld), 32'(exp_ld));
    chk("frame_done", 32'(s_fd), 32'(exp_fd));
  endtask

  // Back-to-back DMA cycles until n bytes of the frame are fetched and any
  // pending line end has been consumed.
  task automatic run_bytes(input int unsigned n);
    int guard = 0;
    while (((m_k < n) || m_gap) && (guard < 5000)) begin
      tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'($urandom));
      guard++;
    end
    n_cmp++;
    if (guard >= 5000) begin
      n_fail++;
      $display("FAIL run_bytes_timeout: fetched %0d, wanted %0d", m_k, n);
    end
  endtask

  initial begin
    logic [15:0] last_addr;
    logic [31:0] r;
    int          ld0;
    int          fd0;
    int          cyc;

    vecs[0]  = '{2'b10, 1'b0, 8'h01, 1'b1, 1'b1, 16'h0900, 1'b1, 3'd0, 1'b0};
    vecs[1]  = '{2'b10, 1'b0, 8'h02, 1'b1, 1'b1, 16'h0901, 1'b1, 3'd1, 1'b0};
    vecs[2]  = '{2'b10, 1'b0, 8'h03, 1'b1, 1'b1, 16'h0902, 1'b1, 3'd2, 1'b0};
    vecs[3]  = '{2'b10, 1'b0, 8'h04, 1'b1, 1'b1, 16'h0903, 1'b1, 3'd3, 1'b0};
    vecs[4]  = '{2'b00, 1'b0, 8'hEE, 1'b0, 1'b1, 16'h0904, 1'b0, 3'd0, 1'b0};
    vecs[5]  = '{2'b10, 1'b1, 8'h05, 1'b1, 1'b1, 16'h0904, 1'b1, 3'd4, 1'b0};
    vecs[6]  = '{2'b10, 1'b1, 8'h06, 1'b1, 1'b1, 16'h0905, 1'b1, 3'd5, 1'b0};
    vecs[7]  = '{2'b10, 1'b0, 8'h07, 1'b1, 1'b1, 16'h0906, 1'b1, 3'd6, 1'b0};
    vecs[8]  = '{2'b10, 1'b0, 8'h08, 1'b1, 1'b1, 16'h0907, 1'b1, 3'd7, 1'b0};
    vecs[9]  = '{2'b00, 1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1};
    vecs[10] = '{2'b10, 1'b0, 8'hAA, 1'b1, 1'b1, 16'h0900, 1'b1, 3'd0, 1'b0};

    reset = 1'b1; clk_enable = 1'b0; SC = 2'b00; DMAO = 1'b1;
    frame_start = 1'b0; data_in = 8'h00;
    @(posedge clk);
    #1;
    tick(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'h5A);
    tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h5A);
    chk("rst_mem_addr", 32'(mem_addr), 32'(START));
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_wr_idx", 32'(wr_idx), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);

    // Idle: DMA cycles before any frame_start fetch nothing.
    tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h11);

    // First line with a stolen cycle and a mid-line DMAO drop, then line 1.
    tick(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 11; i++) begin
      tick(1'b1, vecs[i].sc, vecs[i].dmao, 1'b0, 1'b0, vecs[i].din);
      chk($sformatf("vec%0d_rd", i), 32'(s_rd), 32'(vecs[i].rd));
      if (vecs[i].chk_addr) chk($sformatf("vec%0d_addr", i), 32'(s_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_wr", i), 32'(s_wr), 32'(vecs[i].wr));
      if (vecs[i].wr) begin
        chk($sformatf("vec%0d_idx", i), 32'(s_idx), 32'(vecs[i].idx));
        chk($sformatf("vec%0d_data", i), 32'(s_data), 32'(vecs[i].din));
      end
      chk($sformatf("vec%0d_ld", i), 32'(s_ld), 32'(vecs[i].ld));
    end

    // Four repeated lines, then the next memory row.
    tick(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00);
    ld0 = ld_cnt;
    run_bytes(32);
    chk("four_lines_ld", 32'(ld_cnt - ld0), 32'd4);
    tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h3C);
    chk("row1_start_addr", 32'(s_addr), 32'h0908);

    // Restart mid-line 10.
    run_bytes(83);
    ld0 = ld_cnt;
    tick(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 8'h00);
    tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'hC3);
    chk("restart_addr", 32'(s_addr), 32'h0900);
    chk("restart_idx", 32'(s_idx), 32'd0);
    tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'hC4);
    chk("restart_no_ld", 32'(ld_cnt - ld0), 32'd0);

    // Reset after byte 5.
    tick(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00);
    run_bytes(6);
    chk("pre_rst_idx", 32'(s_idx), 32'd5);
    tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'h77);
    chk("mid_rst_addr", 32'(mem_addr), 32'(START));
    chk("mid_rst_idx", 32'(wr_idx), 32'd0);
    chk("mid_rst_data", 32'(wr_data), 32'd0);
    tick(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00);
    tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h99);
    chk("post_rst_addr", 32'(s_addr), 32'h0900);

    // Randomized full frame.
    tick(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00);
    fd0 = fd_cnt;
    last_addr = 16'h0000;
    cyc = 0;
    while (m_active && (cyc < 20000)) begin
      r = $urandom;
      tick(r[3:2] != 2'b00, (r[1:0] == 2'b00) ? 2'b01 : 2'b10, r[4], 1'b0, 1'b0, 8'($urandom));
      if (s_rd) last_addr = s_addr;
      cyc++;
    end
    n_cmp++;
    if (m_active) begin
      n_fail++;
      $display("FAIL frame_timeout: %0d bytes after %0d cycles", m_k, cyc);
    end
    chk("last_fetch", 32'(last_addr), 32'h09FF);
    chk("frame_done_once", 32'(fd_cnt - fd0), 32'd1);
    tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h12);
    tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h13);
    tick(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00);
    chk("next_frame_addr", 32'(mem_addr), 32'h0900);
    tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 8'h21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
